// File: rtl/raster_pkg.sv
// Shared types and width helpers for the raster scan controller and its coordinate counter.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Never return zero, so a counter port is always at least one bit wide.
   function automatic int COL_W(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic int ROW_W(input int height);
      return (height > 1) ? $clog2(height) : 1;
   endfunction

endpackage

// File: rtl/raster_xy_counter.sv
// Column/row raster counter: column wraps into row, and row wraps at the end of the frame.
module raster_xy_counter
   import raster_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   output logic [COL_W(WIDTH)-1:0]  column,
   output logic [ROW_W(HEIGHT)-1:0] row,
   output logic                     last_col,
   output logic                     last_pix
);

   localparam int CW = COL_W(WIDTH);
   localparam int RW = ROW_W(HEIGHT);

   logic last_row;

   assign last_col = (column == CW'(WIDTH - 1));
   assign last_row = (row == RW'(HEIGHT - 1));
   assign last_pix = last_col && last_row;

   // A clear overrides an advance in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         column <= '0;
         row    <= '0;
      end else if (en) begin
         if (last_col) begin
            column <= '0;
            row    <= last_row ? '0 : row + 1'b1;
         end else begin
            column <= column + 1'b1;
         end
      end
   end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Raster scan controller: runs a WIDTH x HEIGHT scan for one, N or unlimited frames with valid/ready output.
// Optional macro RASTER_HBLANK_EN inserts HBLANK idle cycles after each line.
module raster_scan_ctrl
   import raster_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int HBLANK = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [7:0]               num_frames,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [COL_W(WIDTH)-1:0]  column,
   output logic [ROW_W(HEIGHT)-1:0] row,
   output logic                     sol,
   output logic                     eol,
   output logic                     sof,
   output logic                     eof,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     run_done
);

   if (WIDTH < 2 || HEIGHT < 2 || HBLANK < 1) begin : g_param_check
      $error("raster_scan_ctrl: WIDTH and HEIGHT must be >= 2, HBLANK >= 1");
   end

   state_t     state;
   state_t     state_next;
   logic [7:0] frames_left;
   logic       continuous;
   logic       frame_done_q;
   logic       last_col;
   logic       last_pix;
   logic       accept;
   logic       start_hit;
   logic       abort_hit;
   logic       last_accept;
   logic       final_frame;

`ifdef RASTER_HBLANK_EN
   localparam int BW = $clog2(HBLANK + 1);
   logic [BW-1:0] blank_cnt;
`endif

   // out_valid depends only on registered state, so out_ready never reaches it combinationally.
   assign out_valid   = (state == SCAN);
   assign accept      = out_valid && out_ready;
   assign start_hit   = (state == IDLE) && start && !abort;
   assign abort_hit   = (state != IDLE) && abort;
   assign last_accept = accept && last_pix;
   assign final_frame = !continuous && (frames_left == 8'd1);

   raster_xy_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_xy (
      .clk      (clk),
      .rst      (rst),
      .clr      (abort_hit || start_hit),
      .en       (accept),
      .column   (column),
      .row      (row),
      .last_col (last_col),
      .last_pix (last_pix)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_hit) state_next = SCAN;
         SCAN: begin
            if (last_accept && final_frame) begin
               state_next = DONE;
`ifdef RASTER_HBLANK_EN
            end else if (accept && last_col) begin
               state_next = BLANK;
`endif
            end
         end
`ifdef RASTER_HBLANK_EN
         BLANK: if (blank_cnt == BW'(HBLANK - 1)) state_next = SCAN;
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort_hit) state_next = IDLE;
   end

   // Frame bookkeeping: the count only decrements while more than one frame remains.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         frames_left  <= 8'd0;
         continuous   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_next;
         frame_done_q <= last_accept && !abort;
         if (start_hit) begin
            frames_left <= num_frames;
            continuous  <= (num_frames == 8'd0);
         end else if (abort_hit) begin
            frames_left <= 8'd0;
            continuous  <= 1'b0;
         end else if (last_accept && !continuous && frames_left > 8'd1) begin
            frames_left <= frames_left - 8'd1;
         end
      end
   end

`ifdef RASTER_HBLANK_EN
   always_ff @(posedge clk) begin
      if (rst || state != BLANK) begin
         blank_cnt <= '0;
      end else begin
         blank_cnt <= blank_cnt + 1'b1;
      end
   end
`endif

   assign sol        = out_valid && (column == '0);
   assign eol        = out_valid && last_col;
   assign sof        = out_valid && (column == '0) && (row == '0);
   assign eof        = out_valid && last_pix;
   assign busy       = (state != IDLE);
   assign frame_done = frame_done_q;
   assign run_done   = (state == DONE);

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed self-checking bench for raster_scan_ctrl at WIDTH=4, HEIGHT=3, HBLANK=2.
// Defining RASTER_HBLANK_EN switches the directed run to the line-blanking sequence.
module tb_raster_scan_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int HB = 2;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       start      = 1'b0;
   logic       abort      = 1'b0;
   logic [7:0] num_frames = 8'd0;
   logic       out_ready  = 1'b0;
   logic       out_valid;
   logic [1:0] column;
   logic [1:0] row;
   logic       sol;
   logic       eol;
   logic       sof;
   logic       eof;
   logic       busy;
   logic       frame_done;
   logic       run_done;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   raster_scan_ctrl #(
      .WIDTH  (W),
      .HEIGHT (H),
      .HBLANK (HB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .num_frames (num_frames),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .column     (column),
      .row        (row),
      .sol        (sol),
      .eol        (eol),
      .sof        (sof),
      .eof        (eof),
      .busy       (busy),
      .frame_done (frame_done),
      .run_done   (run_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic [7:0] nf, input logic rdy);
      start      = s;
      abort      = a;
      num_frames = nf;
      out_ready  = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // A valid beat at (r,c); fd is the expected frame_done level in the same cycle.
   task automatic checkBeat(input string tag, input int r, input int c, input logic fd);
      logic [3:0] flags;
      flags = {(c == 0), (c == W - 1), (r == 0 && c == 0), (r == H - 1 && c == W - 1)};
      checkOutput({tag, " valid"}, 32'({out_valid, busy}), 32'd3);
      checkOutput({tag, " coord"}, 32'({row, column}), 32'(r * 4 + c));
      checkOutput({tag, " flags"}, 32'({sol, eol, sof, eof}), 32'(flags));
      checkOutput({tag, " pulses"}, 32'({frame_done, run_done}), 32'({fd, 1'b0}));
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " idle"},
                  32'({out_valid, busy, row, column, sol, eol, sof, eof, frame_done, run_done}), 32'd0);
   endtask

   task automatic checkDone(input string tag);
      checkOutput({tag, " done"}, 32'({out_valid, busy, frame_done, run_done}), 32'b0111);
      checkOutput({tag, " done coord"}, 32'({row, column}), 32'd0);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      checkIdle("reset");
      rst = 1'b0;

      // start and abort together in IDLE must not launch a run
      applyStimulus(1'b1, 1'b1, 8'd1, 1'b1);
      tick();
      checkIdle("start_abort");

`ifdef RASTER_HBLANK_EN
      applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         checkBeat("t6", k / 4, k % 4, 1'b0);
         tick();
         if (k % 4 == 3 && k != 11) begin
            for (int b = 0; b < HB; b++) begin
               checkOutput("t6 blank", 32'({out_valid, busy, row, column}),
                           32'({1'b0, 1'b1, 2'(k / 4 + 1), 2'd0}));
               tick();
            end
         end
      end
      checkDone("t6");
      tick();
      checkIdle("t6 end");
`else
      // single frame, consumer always ready
      applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         checkBeat("t1", k / 4, k % 4, 1'b0);
         tick();
      end
      checkDone("t1");
      tick();
      checkIdle("t1 end");

      // three-cycle stall at (1,2)
      applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         checkBeat("t2", k / 4, k % 4, 1'b0);
         if (k == 6) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               checkBeat("t2 stall", 1, 2, 1'b0);
            end
            out_ready = 1'b1;
         end
         tick();
      end
      checkDone("t2");
      tick();
      checkIdle("t2 end");

      // two frames back to back
      applyStimulus(1'b1, 1'b0, 8'd2, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 24; k++) begin
         checkBeat("t3", (k % 12) / 4, k % 4, (k == 12));
         tick();
      end
      checkDone("t3");
      tick();
      checkIdle("t3 end");

      // abort at (1,1)
      applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkBeat("t4", k / 4, k % 4, 1'b0);
         tick();
      end
      checkBeat("t4 pre_abort", 1, 1, 1'b0);
      abort = 1'b1;
      tick();
      checkIdle("t4 abort");
      abort = 1'b0;
      tick();
      checkIdle("t4 quiet");

      // continuous run with a stray start mid-scan
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 30; k++) begin
         checkBeat("t5", (k % 12) / 4, k % 4, (k == 12 || k == 24));
         start = (k == 2);
         tick();
      end
      start = 1'b0;
      checkBeat("t5 pre_abort", 1, 2, 1'b0);
      abort = 1'b1;
      tick();
      checkIdle("t5 abort");
      abort = 1'b0;

      // reset in the middle of a run
      applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checkBeat("t7", 0, k, 1'b0);
         tick();
      end
      rst = 1'b1;
      tick();
      checkIdle("t7 rst");
      rst = 1'b0;
      tick();
      checkIdle("t7 after");
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
